// File: rtl/analog_mux_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : analog_mux_seq_pkg
// Brief    : Shared state encoding and mode constants for the analog mux
//            break-before-make sequencer.
// Revision : 1.0
// ============================================================================
package analog_mux_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_ON    = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // States in which a manual select request can be taken.
  function automatic logic takes_manual(input state_e s);
    return (s == ST_IDLE) || (s == ST_ON);
  endfunction

endpackage
`default_nettype wire

// File: rtl/analog_mux_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : analog_mux_seq_timer
// Brief    : Loadable down-counter; done_o is high in the last counted cycle.
// Revision : 1.0
// ============================================================================
module analog_mux_seq_timer
  import analog_mux_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // A load of L yields L cycles of count, done_o in the final one.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = (count_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/analog_mux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : analog_mux_sequencer
// Brief    : Break-before-make sequencer driving N_CH analog switches on one
//            shared bus, with manual select and auto-scan modes.
// Revision : 1.0
// ============================================================================
module analog_mux_sequencer
  import analog_mux_seq_pkg::*;
#(
  parameter int N_CH       = 16,
  parameter int BBM_CYCLES = 2,
  parameter int DWELL_W    = 8,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               scan_mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_CH-1:0]    ctrl_out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               on,
  output logic               wrap,
  output logic               sel_err
);

  localparam int               TW       = (DWELL_W > 4) ? DWELL_W : 4;
  localparam logic [TW-1:0]    BBM_LOAD = TW'(BBM_CYCLES);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] s);
    return {{(N_CH-1){1'b0}}, 1'b1} << s;
  endfunction

  state_e           state_q, state_d;
  logic [N_CH-1:0]  ctrl_q, ctrl_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic             scan_q, scan_d;
  logic             pend_scan_q, pend_scan_d;
  logic             pend_idle_q, pend_idle_d;
  logic             pend_wrap_q, pend_wrap_d;
  logic             wrap_q, wrap_d;
  logic             sel_err_q, sel_err_d;

  logic             w_ready;
  logic             w_accept;
  logic             w_range_err;
  logic             w_tmr_load;
  logic             w_tmr_clear;
  logic             w_tmr_done;
  logic [TW-1:0]    w_tmr_val;
  logic [TW-1:0]    w_dwell_load;
  logic [SEL_W-1:0] w_next_ch;

  analog_mux_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (w_tmr_clear),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .done_o     (w_tmr_done)
  );

  assign w_accept     = sel_valid && w_ready;
  assign w_range_err  = 32'(sel_in) >= 32'(N_CH);
  assign w_dwell_load = (dwell == '0) ? TW'(1) : TW'(dwell);
  assign w_next_ch    = (cur_sel_q == LAST_CH) ? '0 : cur_sel_q + SEL_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      cur_sel_q   <= '0;
      pend_sel_q  <= '0;
      scan_q      <= 1'b0;
      pend_scan_q <= 1'b0;
      pend_idle_q <= 1'b0;
      pend_wrap_q <= 1'b0;
      wrap_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      cur_sel_q   <= cur_sel_d;
      pend_sel_q  <= pend_sel_d;
      scan_q      <= scan_d;
      pend_scan_q <= pend_scan_d;
      pend_idle_q <= pend_idle_d;
      pend_wrap_q <= pend_wrap_d;
      wrap_q      <= wrap_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    cur_sel_d   = cur_sel_q;
    pend_sel_d  = pend_sel_q;
    scan_d      = scan_q;
    pend_scan_d = pend_scan_q;
    pend_idle_d = pend_idle_q;
    pend_wrap_d = pend_wrap_q;
    wrap_d      = 1'b0;
    sel_err_d   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_clear = 1'b0;
    w_tmr_val   = '0;

    if (!ena) begin
      // Disable wins over everything; any dead time in progress is dropped.
      state_d     = ST_IDLE;
      ctrl_d      = '0;
      scan_d      = 1'b0;
      w_tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (scan_mode == MODE_SCAN) begin
            state_d    = ST_ON;
            ctrl_d     = onehot('0);
            cur_sel_d  = '0;
            scan_d     = 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = w_dwell_load;
          end else if (w_accept) begin
            if (w_range_err) begin
              sel_err_d = 1'b1;
            end else begin
              state_d   = ST_ON;
              ctrl_d    = onehot(sel_in);
              cur_sel_d = sel_in;
              scan_d    = 1'b0;
            end
          end
        end

        ST_BREAK: begin
          if (w_tmr_done) begin
            if (pend_idle_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_ON;
              ctrl_d    = onehot(pend_sel_q);
              cur_sel_d = pend_sel_q;
              scan_d    = pend_scan_q;
              wrap_d    = pend_wrap_q;
              if (pend_scan_q) begin
                w_tmr_load = 1'b1;
                w_tmr_val  = w_dwell_load;
              end
            end
          end
        end

        ST_ON: begin
          if (scan_mode != scan_q) begin
            state_d     = ST_BREAK;
            ctrl_d      = '0;
            pend_sel_d  = '0;
            pend_scan_d = scan_mode;
            pend_idle_d = (scan_mode == MODE_MANUAL);
            pend_wrap_d = 1'b0;
            w_tmr_load  = 1'b1;
            w_tmr_val   = BBM_LOAD;
          end else if (scan_q) begin
            if (w_tmr_done) begin
              state_d     = ST_BREAK;
              ctrl_d      = '0;
              pend_sel_d  = w_next_ch;
              pend_scan_d = 1'b1;
              pend_idle_d = 1'b0;
              pend_wrap_d = (cur_sel_q == LAST_CH);
              w_tmr_load  = 1'b1;
              w_tmr_val   = BBM_LOAD;
            end
          end else if (w_accept) begin
            if (w_range_err) begin
              sel_err_d = 1'b1;
            end else if (sel_in != cur_sel_q) begin
              state_d     = ST_BREAK;
              ctrl_d      = '0;
              pend_sel_d  = sel_in;
              pend_scan_d = 1'b0;
              pend_idle_d = 1'b0;
              pend_wrap_d = 1'b0;
              w_tmr_load  = 1'b1;
              w_tmr_val   = BBM_LOAD;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          ctrl_d  = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_ready   = !rst && ena && (scan_mode == MODE_MANUAL) && takes_manual(state_q);
    sel_ready = w_ready;
    ctrl_out  = ctrl_q;
    cur_sel   = cur_sel_q;
    on        = (state_q == ST_ON);
    wrap      = wrap_q;
    sel_err   = sel_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_analog_mux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_analog_mux_sequencer
// Brief    : Self-checking bench for analog_mux_sequencer (16 and 12 channels).
// Revision : 1.0
// ============================================================================
module tb_analog_mux_sequencer;

  localparam int N_CH    = 16;
  localparam int N_CH_B  = 12;
  localparam int BBM     = 2;
  localparam int DWELL_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        scan_mode = 1'b0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel_in = 4'd0;
  logic [7:0]  dwell = 8'd0;

  logic        sel_ready, on, wrap, sel_err;
  logic [15:0] ctrl_out;
  logic [3:0]  cur_sel;
  logic        sel_ready_b, on_b, wrap_b, sel_err_b;
  logic [11:0] ctrl_out_b;
  logic [3:0]  cur_sel_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  analog_mux_sequencer #(.N_CH(N_CH), .BBM_CYCLES(BBM), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .scan_mode(scan_mode), .sel_in(sel_in),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .dwell(dwell), .ctrl_out(ctrl_out),
    .cur_sel(cur_sel), .on(on), .wrap(wrap), .sel_err(sel_err)
  );

  analog_mux_sequencer #(.N_CH(N_CH_B), .BBM_CYCLES(BBM), .DWELL_W(DWELL_W)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .scan_mode(scan_mode), .sel_in(sel_in),
    .sel_valid(sel_valid), .sel_ready(sel_ready_b), .dwell(dwell), .ctrl_out(ctrl_out_b),
    .cur_sel(cur_sel_b), .on(on_b), .wrap(wrap_b), .sel_err(sel_err_b)
  );

  // Reference helpers: switch pattern for a channel, effective dwell length.
  function automatic logic [15:0] oh16(input int k);
    logic [15:0] one = 16'd1;
    return one << k;
  endfunction

  function automatic logic [11:0] oh12(input int k);
    logic [11:0] one = 12'd1;
    return one << k;
  endfunction

  function automatic int eff(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; scan_mode = 1'b0; sel_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Never more than one switch closed, on either instance.
  always @(negedge clk) begin
    n_checks++;
    if (!$onehot0(ctrl_out) || !$onehot0(ctrl_out_b))
      $display("FAIL onehot0 ctrl_out=%h ctrl_out_b=%h required at most one bit", ctrl_out, ctrl_out_b);
    else n_pass++;
  end

  task automatic test_reset();
    ena = 1'(($urandom_range(0, 1))); scan_mode = 1'($urandom_range(0, 1));
    sel_valid = 1'($urandom_range(0, 1)); sel_in = 4'($urandom); dwell = 8'($urandom);
    rst = 1'b1;
    repeat (3) begin
      step();
      n_checks++;
      if ({ctrl_out, on, cur_sel, sel_ready, wrap, sel_err} !== 25'd0)
        $display("FAIL reset_state got %h required 0", {ctrl_out, on, cur_sel, sel_ready, wrap, sel_err});
      else n_pass++;
      n_checks++;
      if ({ctrl_out_b, on_b, cur_sel_b, sel_ready_b, wrap_b, sel_err_b} !== 21'd0)
        $display("FAIL reset_state_b got %h required 0", {ctrl_out_b, on_b, cur_sel_b, sel_ready_b, wrap_b, sel_err_b});
      else n_pass++;
    end
    rst = 1'b0; ena = 1'b0; scan_mode = 1'b0; sel_valid = 1'b0;
    step();
  endtask

  task automatic test_manual_basic();
    ena = 1'b1; scan_mode = 1'b0; sel_valid = 1'b0; dwell = 8'd0;
    step();
    n_checks++;
    if ({sel_ready, on, ctrl_out} !== {1'b1, 1'b0, 16'h0})
      $display("FAIL idle_ready got %h required %h", {sel_ready, on, ctrl_out}, {1'b1, 1'b0, 16'h0});
    else n_pass++;
    sel_in = 4'd5; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    n_checks++;
    if ({ctrl_out, on, cur_sel} !== {16'h0020, 1'b1, 4'd5})
      $display("FAIL idle_close got %h required %h", {ctrl_out, on, cur_sel}, {16'h0020, 1'b1, 4'd5});
    else n_pass++;
  endtask

  task automatic test_manual_switch();
    sel_in = 4'd9; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    for (int i = 0; i < BBM; i++) begin
      n_checks++;
      if ({ctrl_out, on, sel_ready} !== 18'd0)
        $display("FAIL bbm_gap cyc%0d got %h required 0", i, {ctrl_out, on, sel_ready});
      else n_pass++;
      step();
    end
    n_checks++;
    if ({ctrl_out, on, cur_sel, sel_ready} !== {16'h0200, 1'b1, 4'd9, 1'b1})
      $display("FAIL bbm_close got %h required %h", {ctrl_out, on, cur_sel, sel_ready}, {16'h0200, 1'b1, 4'd9, 1'b1});
    else n_pass++;
  endtask

  task automatic test_same_target();
    sel_in = 4'd9; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    repeat (3) begin
      n_checks++;
      if ({ctrl_out, on, cur_sel, sel_ready, sel_err} !== {16'h0200, 1'b1, 4'd9, 1'b1, 1'b0})
        $display("FAIL same_target got %h required %h", {ctrl_out, on, cur_sel, sel_ready, sel_err}, {16'h0200, 1'b1, 4'd9, 1'b1, 1'b0});
      else n_pass++;
      step();
    end
  endtask

  // Random manual targets; junk requests during dead time must be ignored.
  task automatic test_random_manual();
    int cur = 9;
    for (int it = 0; it < 24; it++) begin
      int t   = int'($urandom_range(0, N_CH - 1));
      int gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        n_checks++;
        if ({ctrl_out, on, sel_ready} !== {oh16(cur), 1'b1, 1'b1})
          $display("FAIL manual_hold got %h required %h", {ctrl_out, on, sel_ready}, {oh16(cur), 1'b1, 1'b1});
        else n_pass++;
        step();
      end
      sel_in = 4'(t); sel_valid = 1'b1;
      step();
      sel_valid = 1'b0;
      if (t != cur) begin
        for (int b = 0; b < BBM; b++) begin
          n_checks++;
          if ({ctrl_out, on, sel_ready} !== 18'd0)
            $display("FAIL rand_gap got %h required 0", {ctrl_out, on, sel_ready});
          else n_pass++;
          sel_valid = (b < BBM - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          sel_in = 4'($urandom);
          step();
        end
      end
      n_checks++;
      if ({ctrl_out, on, cur_sel} !== {oh16(t), 1'b1, 4'(t)})
        $display("FAIL rand_close got %h required %h", {ctrl_out, on, cur_sel}, {oh16(t), 1'b1, 4'(t)});
      else n_pass++;
      cur = t;
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    ena = 1'b1; scan_mode = 1'b0;
    sel_in = 4'd14; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    n_checks++;
    if ({sel_err_b, on_b, ctrl_out_b, sel_err} !== {1'b1, 1'b0, 12'h0, 1'b0})
      $display("FAIL oor_idle got %h required %h", {sel_err_b, on_b, ctrl_out_b, sel_err}, {1'b1, 1'b0, 12'h0, 1'b0});
    else n_pass++;
    step();
    n_checks++;
    if (sel_err_b !== 1'b0)
      $display("FAIL oor_pulse_len got %b required 0", sel_err_b);
    else n_pass++;
    sel_in = 4'd3; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    n_checks++;
    if ({ctrl_out_b, on_b, cur_sel_b} !== {12'h008, 1'b1, 4'd3})
      $display("FAIL b_close3 got %h required %h", {ctrl_out_b, on_b, cur_sel_b}, {12'h008, 1'b1, 4'd3});
    else n_pass++;
    repeat (BBM + 1) step();
    for (int i = 0; i < 4; i++) begin
      sel_in = 4'($urandom_range(N_CH_B, 15)); sel_valid = 1'b1;
      step();
      sel_valid = 1'b0;
      n_checks++;
      if ({sel_err_b, ctrl_out_b, on_b, cur_sel_b} !== {1'b1, 12'h008, 1'b1, 4'd3})
        $display("FAIL oor_on got %h required %h", {sel_err_b, ctrl_out_b, on_b, cur_sel_b}, {1'b1, 12'h008, 1'b1, 4'd3});
      else n_pass++;
      step();
      n_checks++;
      if ({sel_err_b, ctrl_out_b} !== {1'b0, 12'h008})
        $display("FAIL oor_after got %h required %h", {sel_err_b, ctrl_out_b}, {1'b0, 12'h008});
      else n_pass++;
    end
  endtask

  // Auto-scan: channel list 0,1,..,15,0,1 each held max(dwell,1) then BBM open.
  task automatic test_scan(input int d0, input bit rnd);
    int used;
    int k = 0;
    do_reset();
    ena = 1'b1; scan_mode = 1'b0;
    step();
    dwell = 8'(d0); scan_mode = 1'b1;
    used = eff(dwell);
    step();
    for (int v = 0; v < N_CH + 2; v++) begin
      for (int i = 0; i < used; i++) begin
        logic ew = (i == 0) && (k == 0) && (v != 0);
        n_checks++;
        if ({ctrl_out, on, cur_sel, wrap, sel_ready} !== {oh16(k), 1'b1, 4'(k), ew, 1'b0})
          $display("FAIL scan_on v%0d i%0d got %h required %h", v, i, {ctrl_out, on, cur_sel, wrap, sel_ready}, {oh16(k), 1'b1, 4'(k), ew, 1'b0});
        else n_pass++;
        if (rnd && $urandom_range(0, 2) == 0) dwell = 8'($urandom_range(0, 4));
        step();
      end
      for (int b = 0; b < BBM; b++) begin
        n_checks++;
        if ({ctrl_out, on, wrap} !== 18'd0)
          $display("FAIL scan_gap v%0d got %h required 0", v, {ctrl_out, on, wrap});
        else n_pass++;
        if (b == BBM - 1) used = eff(dwell);
        step();
      end
      k = (k + 1) % N_CH;
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    ena = 1'b1; dwell = 8'($urandom_range(3, 6)); scan_mode = 1'b1;
    step();
    repeat ($urandom_range(0, 2)) step();
    scan_mode = 1'b0;
    step();
    for (int b = 0; b < BBM; b++) begin
      n_checks++;
      if ({ctrl_out, on} !== 17'd0)
        $display("FAIL scan_exit_gap got %h required 0", {ctrl_out, on});
      else n_pass++;
      step();
    end
    repeat (2) begin
      n_checks++;
      if ({ctrl_out, on, sel_ready} !== {16'h0, 1'b0, 1'b1})
        $display("FAIL scan_exit_idle got %h required %h", {ctrl_out, on, sel_ready}, {16'h0, 1'b0, 1'b1});
      else n_pass++;
      step();
    end
    sel_in = 4'd7; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    dwell = 8'd2; scan_mode = 1'b1;
    step();
    for (int b = 0; b < BBM; b++) begin
      n_checks++;
      if ({ctrl_out, on, sel_ready} !== 18'd0)
        $display("FAIL scan_entry_gap got %h required 0", {ctrl_out, on, sel_ready});
      else n_pass++;
      step();
    end
    n_checks++;
    if ({ctrl_out, on, cur_sel, wrap} !== {16'h0001, 1'b1, 4'd0, 1'b0})
      $display("FAIL scan_entry_ch0 got %h required %h", {ctrl_out, on, cur_sel, wrap}, {16'h0001, 1'b1, 4'd0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_ena_drop();
    do_reset();
    ena = 1'b1; scan_mode = 1'b0;
    sel_in = 4'd5; sel_valid = 1'b1; step();
    sel_in = 4'd9; step();
    sel_valid = 1'b0; ena = 1'b0;
    step();
    n_checks++;
    if ({ctrl_out, on, sel_ready} !== 18'd0)
      $display("FAIL ena_drop got %h required 0", {ctrl_out, on, sel_ready});
    else n_pass++;
    ena = 1'b1;
    step();
    repeat (4) begin
      n_checks++;
      if ({ctrl_out, on, sel_ready} !== {16'h0, 1'b0, 1'b1})
        $display("FAIL ena_idle got %h required %h", {ctrl_out, on, sel_ready}, {16'h0, 1'b0, 1'b1});
      else n_pass++;
      step();
    end
    sel_in = 4'd2; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    n_checks++;
    if ({ctrl_out, cur_sel} !== {16'h0004, 4'd2})
      $display("FAIL ena_reclose got %h required %h", {ctrl_out, cur_sel}, {16'h0004, 4'd2});
    else n_pass++;
    ena = 1'b0;
    step();
    n_checks++;
    if ({ctrl_out, on} !== 17'd0)
      $display("FAIL ena_drop_on got %h required 0", {ctrl_out, on});
    else n_pass++;
  endtask

  task automatic test_rst_abort();
    do_reset();
    ena = 1'b1; dwell = 8'd6; scan_mode = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({ctrl_out, on, sel_ready, wrap} !== 19'd0)
      $display("FAIL rst_dwell got %h required 0", {ctrl_out, on, sel_ready, wrap});
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if ({ctrl_out, on, cur_sel, wrap} !== {16'h0001, 1'b1, 4'd0, 1'b0})
      $display("FAIL rst_scan_restart got %h required %h", {ctrl_out, on, cur_sel, wrap}, {16'h0001, 1'b1, 4'd0, 1'b0});
    else n_pass++;
    do_reset();
    ena = 1'b1;
    sel_in = 4'd5; sel_valid = 1'b1; step();
    sel_in = 4'd9; step();
    sel_valid = 1'b0; rst = 1'b1;
    step();
    n_checks++;
    if ({ctrl_out, on} !== 17'd0)
      $display("FAIL rst_break got %h required 0", {ctrl_out, on});
    else n_pass++;
    rst = 1'b0; sel_in = 4'd9; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    n_checks++;
    if ({ctrl_out, on, cur_sel} !== {16'h0200, 1'b1, 4'd9})
      $display("FAIL rst_manual_restart got %h required %h", {ctrl_out, on, cur_sel}, {16'h0200, 1'b1, 4'd9});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_manual_basic();
    test_manual_switch();
    test_same_target();
    test_random_manual();
    test_out_of_range();
    test_scan(3, 1'b0);
    test_scan(0, 1'b0);
    test_scan(int'($urandom_range(0, 4)), 1'b1);
    test_mode_switch();
    test_ena_drop();
    test_rst_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
